// File: rtl/instr_mem_loadable_pkg.sv
// instr_mem_loadable_pkg: shared defaults, FSM encoding and opcode field layout for the lab ISA
package instr_mem_loadable_pkg;
  localparam int INSTR_W_DEF = 9;
  localparam int ADDR_W_DEF = 8;
  localparam logic [INSTR_W_DEF-1:0] NOP_DEF = 9'b0000_00_000;
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 5;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_DONE = 2'd2;
  localparam state_t ST_RUN  = 2'd3;
  function automatic logic [OPC_MSB-OPC_LSB:0] opcode(input logic [INSTR_W_DEF-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction
endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array: DEPTH x INSTR_W storage with one synchronous write and one synchronous read port
module instr_mem_array
  import instr_mem_loadable_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 256
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: run-time loadable instruction memory; streamed load port, registered fetch port
module instr_mem_loadable
  import instr_mem_loadable_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 256,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  output logic               load_done,
  output logic [ADDR_W:0]    load_count,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  input  logic               fetch_stall,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic               fetch_fault,
  output logic               busy
);
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  state_t state, state_nx;
  logic wr_en, rd_en, run_fetch, in_range, hit_q;
  logic [INSTR_W-1:0] rd_data;
  // load_count doubles as the write pointer; anything at or above it reads as unloaded
  assign in_range   = {1'b0, fetch_addr} < load_count;
  assign run_fetch  = state == ST_RUN && !load_en;
  assign load_ready = state == ST_LOAD && load_en && load_count <= CNT_LAST;
  assign wr_en      = load_valid && load_ready;
  assign rd_en      = run_fetch && !fetch_stall && fetch_req && in_range;
  assign load_done  = state == ST_DONE;
  assign busy       = state != ST_RUN;
  assign fetch_instr = hit_q ? rd_data : NOP_INSTR;
  always_comb begin
    state_nx = state == ST_IDLE ? (load_en ? ST_LOAD : ST_RUN)
             : state == ST_LOAD ? ((!load_en || (wr_en && load_count == CNT_LAST)) ? ST_DONE : ST_LOAD)
             : state == ST_DONE ? ST_RUN
             : (load_en ? ST_LOAD : ST_RUN);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      load_count  <= '0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx == ST_LOAD && state != ST_LOAD) load_count <= '0;
      else if (wr_en) load_count <= load_count + CNT_ONE;
      // hit_q selects the array output; cleared it makes fetch_instr show the NOP fill
      if (!run_fetch) fetch_valid <= 1'b0;
      else if (!fetch_stall) begin
        fetch_valid <= fetch_req;
        if (fetch_req) begin
          hit_q       <= in_range;
          fetch_fault <= !in_range;
        end
      end
    end
  end
  instr_mem_array #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (load_count[ADDR_W-1:0]),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (fetch_addr),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: randomized self-checking bench against a program-array reference model
module tb_instr_mem_loadable;
  localparam int DEPTH = 256;
  localparam logic [8:0] NOP = 9'h000;
  logic clk, rst_n, load_en, load_valid, load_ready, load_done;
  logic [8:0] load_data, fetch_instr, exp_instr;
  logic [8:0] load_count;
  logic fetch_req, fetch_stall, fetch_valid, fetch_fault, busy;
  logic [7:0] fetch_addr;
  logic exp_valid, exp_fault;
  logic [8:0] model_mem [DEPTH];
  int model_count, checks, errors, done_seen;

  instr_mem_loadable dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .load_count(load_count),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    if (load_done === 1'b1) done_seen++;
  endtask

  task automatic cyc(input bit req, input int a, input bit st);
    fetch_req = req;
    fetch_addr = 8'(a);
    fetch_stall = st;
    if (!st) begin
      exp_valid = req;
      if (req) begin
        exp_fault = a >= model_count;
        exp_instr = exp_fault ? NOP : model_mem[a];
      end
    end
    tick;
    checks++;
    if (fetch_valid !== exp_valid) begin errors++; $display("FAIL fetch_valid addr=%0d: got %b expected %b", a, fetch_valid, exp_valid); end
    checks++;
    if (fetch_instr !== exp_instr) begin errors++; $display("FAIL fetch_instr addr=%0d: got %h expected %h", a, fetch_instr, exp_instr); end
    checks++;
    if (fetch_fault !== exp_fault) begin errors++; $display("FAIL fetch_fault addr=%0d: got %b expected %b", a, fetch_fault, exp_fault); end
  endtask

  task automatic load_prog(input int n, input bit rnd);
    fetch_req = 0; fetch_stall = 0; done_seen = 0;
    load_en = 1; load_valid = 0;
    tick;
    model_count = 0;
    exp_valid = 0;
    checks++;
    if (load_count !== 9'd0 || busy !== 1'b1) begin errors++; $display("FAIL load_entry: count=%0d busy=%b expected 0 1", load_count, busy); end
    for (int i = 0; i < n; i++) begin
      load_valid = 1;
      load_data = rnd ? 9'($urandom) : 9'(i);
      load_en = model_count < DEPTH;
      #1;
      checks++;
      if (load_ready !== (model_count < DEPTH)) begin errors++; $display("FAIL load_ready word=%0d: got %b expected %b", i, load_ready, model_count < DEPTH); end
      if (model_count < DEPTH) begin
        model_mem[model_count] = load_data;
        model_count++;
      end
      tick;
    end
    if (model_count < DEPTH) begin
      load_valid = 1; load_data = 9'($urandom); load_en = 0;
      #1;
      checks++;
      if (load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_on_fall: got %b expected 0", load_ready); end
      tick;
      load_valid = 0;
      checks++;
      if (load_done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL done_cycle: done=%b busy=%b expected 1 1", load_done, busy); end
      tick;
      checks++;
      if (busy !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL run_entry: busy=%b done=%b expected 0 0", busy, load_done); end
    end else begin
      load_valid = 0; load_en = 0;
      tick;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL run_after_full: busy=%b expected 0", busy); end
    end
    checks++;
    if (done_seen !== 1) begin errors++; $display("FAIL done_pulses: got %0d expected 1", done_seen); end
    checks++;
    if (load_count !== 9'(model_count)) begin errors++; $display("FAIL load_count: got %0d expected %0d", load_count, model_count); end
  endtask

  task automatic test_reset;
    rst_n = 0; load_en = 0; load_valid = 0; load_data = 0;
    fetch_req = 0; fetch_addr = 0; fetch_stall = 0;
    model_count = 0; exp_valid = 0; exp_instr = NOP; exp_fault = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (load_count !== 9'd0 || load_ready !== 1'b0 || load_done !== 1'b0)
      begin errors++; $display("FAIL reset_load: count=%0d ready=%b done=%b expected 0 0 0", load_count, load_ready, load_done); end
    checks++;
    if (fetch_valid !== 1'b0 || fetch_instr !== NOP || fetch_fault !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL reset_fetch: valid=%b instr=%h fault=%b busy=%b expected 0 000 0 1", fetch_valid, fetch_instr, fetch_fault, busy); end
    @(negedge clk);
    rst_n = 1;
    fetch_req = 1;
    tick;
    checks++;
    if (fetch_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_fetch: valid=%b busy=%b expected 0 0", fetch_valid, busy); end
    cyc(1, 0, 0);
    cyc(0, 0, 0);
  endtask

  task automatic test_load_fetch;
    load_prog(16, 0);
    for (int a = 0; a < 16; a++) cyc(1, a, 0);
    cyc(1, 20, 0);
    cyc(1, 15, 0);
    checks++;
    if (fetch_instr !== 9'h00F || fetch_fault !== 1'b0) begin errors++; $display("FAIL addr15: instr=%h fault=%b expected 00f 0", fetch_instr, fetch_fault); end
    cyc(1, 16, 0);
    cyc(0, 0, 0);
  endtask

  task automatic test_stall;
    cyc(1, 3, 0);
    cyc(1, 4, 1);
    checks++;
    if (fetch_instr !== 9'h003 || fetch_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: instr=%h valid=%b expected 003 1", fetch_instr, fetch_valid); end
    cyc(0, 0, 0);
    checks++;
    if (fetch_instr !== 9'h003) begin errors++; $display("FAIL stall_drop: instr=%h expected 003", fetch_instr); end
  endtask

  task automatic test_overflow;
    load_prog(DEPTH + 2, 1);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 255, 0);
    repeat (10) cyc(1, $urandom_range(0, 255), 0);
  endtask

  task automatic test_reset_mid_load;
    fetch_req = 0; done_seen = 0;
    load_en = 1;
    tick;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1; load_data = 9'($urandom);
      tick;
    end
    rst_n = 0;
    #1;
    checks++;
    if (load_count !== 9'd0 || busy !== 1'b1 || load_ready !== 1'b0 || load_done !== 1'b0)
      begin errors++; $display("FAIL mid_reset: count=%0d busy=%b ready=%b done=%b expected 0 1 0 0", load_count, busy, load_ready, load_done); end
    load_en = 0; load_valid = 0;
    model_count = 0; exp_valid = 0; exp_instr = NOP; exp_fault = 0;
    @(negedge clk);
    rst_n = 1;
    tick;
    checks++;
    if (busy !== 1'b0 || done_seen !== 0 || load_count !== 9'd0)
      begin errors++; $display("FAIL after_mid_reset: busy=%b done_pulses=%0d count=%0d expected 0 0 0", busy, done_seen, load_count); end
    cyc(1, 0, 0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 40);
      load_prog(n, 1);
      repeat (50) cyc($urandom_range(0, 3) != 0,
                      $urandom_range(0, 1) != 0 ? $urandom_range(0, n + 4) : $urandom_range(0, 255),
                      $urandom_range(0, 4) == 0);
    end
  endtask

  initial begin
    checks = 0; errors = 0; done_seen = 0;
    test_reset;
    test_load_fetch;
    test_stall;
    test_overflow;
    test_reset_mid_load;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
